// File: rtl/uart_rx_deserializer_if.sv
// Receive-buffer handshake between the UART deserializer and its consumer.
// valid/ready: the producer raises rx_valid with rx_data and holds both
// stable until a cycle where rx_valid && rx_ready, which is the transfer.
interface uart_rx_deserializer_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    rx_valid;
  logic                    rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-flop synchroniser, mid-bit sampling, LSB-first
// character assembly, single-entry holding register on a valid/ready bus.
// Optional even-parity bit enabled with macro UART_RX_PARITY_EN.
module uart_rx_deserializer #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  uart_rx_deserializer_if.master        rx_bus,
  output logic                          busy,
  output logic                          framing_error,
  output logic                          overrun,
  output logic                          parity_error,
  output logic [2:0]                    dbg_state_o
);
  localparam int CPB = CLK_FREQ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB + 1);
  localparam int IW = $clog2(PAYLOAD_BITS);
  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_WAIT_IDLE = 3'd4,
    S_PARITY    = 3'd5
`else
    S_WAIT_IDLE = 3'd4
`endif
  } state_t;

  logic [1:0]              sync_q;
  logic                    rxs;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    fe_q, fe_d;
  logic                    ov_q, ov_d;
  logic                    bit_tick;
  logic                    complete;
`ifdef UART_RX_PARITY_EN
  logic                    par_q, par_d;
  logic                    pe_q, pe_d;
`endif

  assign rxs = sync_q[1];

  // Two-flop synchroniser; idle-high reset so no false start after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign bit_tick = (cnt_q == CPB_LAST);

  // Frame FSM next state plus holding-register delivery decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    complete = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    pe_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (rxs) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A completing character may replace one being consumed this same cycle.
    if (complete) begin
      if (!valid_q || rx_bus.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      pe_d = ^{shift_q, par_q};
`endif
    end else if (valid_q && rx_bus.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign rx_bus.rx_data  = data_q;
  assign rx_bus.rx_valid = valid_q;
  assign busy            = (state_q != S_IDLE);
  assign framing_error   = fe_q;
  assign overrun         = ov_q;
  assign dbg_state_o     = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error    = pe_q;
`else
  assign parity_error    = 1'b0;
`endif
endmodule
